mem_access_unit: RTL and testbench

Responder side of the load/store control interface (MemRW, RWType). Accepts one load/store request per transaction from the datapath and performs the byte/half/word access against a 32-bit word-addressed data memory through a req/ack handshake. Merges store data with byte strobes, and extracts and sign- or zero-extends load data. Sits between the execute stage and the data RAM or bus bridge.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/load_extract.sv | 25 ++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state constants and size helpers for the load/store responder.
package mem_pkg;

   localparam logic [2:0] RW_B  = 3'b000;
   localparam logic [2:0] RW_H  = 3'b001;
   localparam logic [2:0] RW_W  = 3'b010;
   localparam logic [2:0] RW_BU = 3'b100;
   localparam logic [2:0] RW_HU = 3'b101;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ACC0 = 2'd1;
   localparam state_t ST_ACC1 = 2'd2;
   localparam state_t ST_RESP = 2'd3;

   // Size in bytes from the low two bits of RWType; 0 for the reserved code.
   function automatic logic [2:0] size_of(input logic [1:0] sz_code);
      case (sz_code)
         2'b00:   size_of = 3'd1;
         2'b01:   size_of = 3'd2;
         2'b10:   size_of = 3'd4;
         default: size_of = 3'd0;
      endcase
   endfunction

   function automatic logic [3:0] mask_of(input logic [1:0] sz_code);
      case (sz_code)
         2'b00:   mask_of = MASK_B;
         2'b01:   mask_of = MASK_H;
         2'b10:   mask_of = MASK_W;
         default: mask_of = 4'b0000;
      endcase
   endfunction

   function automatic logic is_legal(input logic [2:0] rw_type, input logic is_store);
      case (rw_type)
         RW_B, RW_H, RW_W: is_legal = 1'b1;
         RW_BU, RW_HU:     is_legal = !is_store;
         default:          is_legal = 1'b0;
      endcase
   endfunction

   // An access crosses a word boundary when offset + size exceeds four bytes.
   function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] sz_code);
      is_misaligned = ({2'b00, off} + {1'b0, size_of(sz_code)}) > 4'd4;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus bundle; slave is the access unit, master the environment.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              MemRW;
   logic [2:0]        RWType;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, MemRW, RWType, addr, wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
   );

   modport master (
      output req_valid, MemRW, RWType, addr, wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
   );
endinterface

// File: rtl/load_extract.sv
// Selects the addressed bytes from a two-word window and sign- or zero-extends them.
module load_extract
   import mem_pkg::*;
(
   input  logic [63:0] words_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  rw_type_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;
   assign shifted = 32'(words_i >> {off_i, 3'b000});

   always_comb begin
      case (rw_type_i)
         RW_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
         RW_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
         RW_W:    data_o = shifted;
         RW_BU:   data_o = {24'h0, shifted[7:0]};
         RW_HU:   data_o = {16'h0, shifted[15:0]};
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: one datapath request becomes one or two word accesses on the RAM bus.
// Build option MEM_MISALIGN_SPLIT_EN splits word-crossing accesses; without it they return an error.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   mem_access_unit_if.slave bus
);

   state_t              state_q, state_d;
   logic                err_q, err_d;
   logic                we_q;
   logic [2:0]          rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   word0_q;
   logic [DATA_W-1:0]   word1;
   logic                accept;
   logic [1:0]          off;
   logic [ADDR_W-1:0]   word_addr;
   logic [31:0]         load_data;

   assign accept    = (state_q == ST_IDLE) && bus.req_valid;
   assign off       = addr_q[1:0];
   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef MEM_MISALIGN_SPLIT_EN
   logic [DATA_W-1:0] word1_q;
   logic [7:0]        lane_strb;
   logic [63:0]       lane_data;
   logic              acc_split;

   // Lane placement spans two words; the upper half feeds the second access.
   assign lane_strb = {4'b0000, mask_of(rw_q[1:0])} << off;
   assign lane_data = {32'h0, wdata_q} << {off, 3'b000};
   assign acc_split = is_misaligned(off, rw_q[1:0]);
   assign word1     = word1_q;
`else
   logic [3:0]        lane_strb;
   logic [31:0]       lane_data;

   assign lane_strb = mask_of(rw_q[1:0]) << off;
   assign lane_data = wdata_q << {off, 3'b000};
   assign word1     = '0;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               err_d = 1'b0;
               if (!is_legal(bus.RWType, bus.MemRW)) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
               end
`ifndef MEM_MISALIGN_SPLIT_EN
               else if (is_misaligned(bus.addr[1:0], bus.RWType[1:0])) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
               end
`endif
               else begin
                  state_d = ST_ACC0;
               end
            end
         end
         ST_ACC0: begin
            if (bus.mem_ack) begin
`ifdef MEM_MISALIGN_SPLIT_EN
               state_d = acc_split ? ST_ACC1 : ST_RESP;
`else
               state_d = ST_RESP;
`endif
            end
         end
`ifdef MEM_MISALIGN_SPLIT_EN
         ST_ACC1: begin
            if (bus.mem_ack) state_d = ST_RESP;
         end
`endif
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         rw_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         word0_q <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
         word1_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= bus.MemRW;
            rw_q    <= bus.RWType;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
         end
         if (state_q == ST_ACC0 && bus.mem_ack) word0_q <= bus.mem_rdata;
`ifdef MEM_MISALIGN_SPLIT_EN
         if (state_q == ST_ACC1 && bus.mem_ack) word1_q <= bus.mem_rdata;
`endif
      end
   end

   load_extract u_load_extract (
      .words_i   ({word1, word0_q}),
      .off_i     (off),
      .rw_type_i (rw_q),
      .data_o    (load_data)
   );

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_err   = (state_q == ST_RESP) && err_q;
   assign bus.resp_rdata = (state_q == ST_RESP && !err_q && !we_q) ? load_data : 32'h0;
   assign bus.mem_req    = (state_q == ST_ACC0) || (state_q == ST_ACC1);

   // Bus outputs are decoded from held registers, so they stay stable while waiting for ack.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wstrb = 4'b0000;
      bus.mem_wdata = 32'h0;
      case (state_q)
         ST_ACC0: begin
            bus.mem_addr = word_addr;
            bus.mem_we   = we_q;
            if (we_q) begin
               bus.mem_wstrb = lane_strb[3:0];
               bus.mem_wdata = lane_data[31:0];
            end
         end
`ifdef MEM_MISALIGN_SPLIT_EN
         ST_ACC1: begin
            bus.mem_addr = word_addr + ADDR_W'(4);
            bus.mem_we   = we_q;
            if (we_q) begin
               bus.mem_wstrb = lane_strb[7:4];
               bus.mem_wdata = lane_data[63:32];
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses are queued at issue and popped on resp_valid.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(32)) bus ();

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } beat_t;

   exp_t        sb[$];
   beat_t       beats[$];
   logic [31:0] mem [logic [29:0]];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ack_delay = 0;
   logic stray_ack = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Memory responder: acks after ack_delay wait cycles, applies strobed writes, logs each beat.
   initial begin
      int          wait_cnt;
      logic [31:0] hold_addr;
      logic [3:0]  hold_strb;
      logic [29:0] k;
      logic [31:0] w;
      wait_cnt    = 0;
      hold_addr   = '0;
      hold_strb   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 32'h0;
         if (stray_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hFFFF_FFFF;
         end else if (bus.mem_req) begin
            if (wait_cnt == 0) begin
               hold_addr = bus.mem_addr;
               hold_strb = bus.mem_wstrb;
            end else begin
               check("hold_addr", bus.mem_addr, hold_addr);
               check("hold_strb", bus.mem_wstrb, hold_strb);
               check("busy_ready", bus.req_ready, 1'b0);
            end
            if (wait_cnt >= ack_delay) begin
               k = bus.mem_addr[31:2];
               w = mem.exists(k) ? mem[k] : 32'h0;
               bus.mem_rdata = w;
               if (bus.mem_we) begin
                  for (int i = 0; i < 4; i++)
                     if (bus.mem_wstrb[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
                  mem[k] = w;
               end
               beats.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata});
               bus.mem_ack = 1'b1;
               wait_cnt    = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Response monitor: pops the scoreboard and checks data, error flag and arrival cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.resp_valid) begin
            check("resp_ready_low", bus.req_ready, 1'b0);
            if (sb.size() == 0) begin
               check("unexpected_resp", 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               check("resp_rdata", bus.resp_rdata, e.rdata);
               check("resp_err", bus.resp_err, e.err);
               check("resp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         check("resp_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [2:0] rw, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat);
      int guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.MemRW     = we;
      bus.RWType    = rw;
      bus.addr      = a;
      bus.wdata     = wd;
      sb.push_back('{er, ee, cyc + lat});
      @(negedge clk);
      bus.req_valid = 1'b0;
      drain();
   endtask

   task automatic check_beat(input string tag, input logic [31:0] a, input logic we,
                             input logic [3:0] s, input logic [31:0] d);
      beat_t b;
      if (beats.size() == 0) begin
         check({tag, "_missing"}, 1'b1, 1'b0);
      end else begin
         b = beats.pop_front();
         check({tag, "_addr"}, b.addr, a);
         check({tag, "_we"}, b.we, we);
         check({tag, "_strb"}, b.strb, s);
         if (we) check({tag, "_wdata"}, b.wdata, d);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.MemRW     = 1'b0;
      bus.RWType    = 3'b000;
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1'b1);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_resp_err", bus.resp_err, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_wstrb", bus.mem_wstrb, 4'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      rst = 1'b0;

      // Aligned loads.
      mem[30'h40] = 32'hDEAD_BEEF;
      issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
      check("lw_beats", beats.size(), 1);
      check_beat("lw", 32'h100, 1'b0, 4'h0, 32'h0);

      mem[30'h40] = 32'h80FF_FFFF;
      issue(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
      check_beat("lb", 32'h100, 1'b0, 4'h0, 32'h0);
      issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 2);
      check_beat("lbu", 32'h100, 1'b0, 4'h0, 32'h0);

      // Stores and read-back of merged lanes.
      issue(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 1'b0, 2);
      check_beat("sh", 32'h100, 1'b1, 4'b1100, 32'hABCD_0000);
      issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hABCD_FFFF, 1'b0, 2);
      issue(1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b0, 2);
      issue(1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_ABCD, 1'b0, 2);
      issue(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_ABCD, 1'b0, 2);
      beats.delete();
      issue(1'b1, 3'b000, 32'h101, 32'h1234_565A, 32'h0, 1'b0, 2);
      check_beat("sb", 32'h100, 1'b1, 4'b0010, 32'h3456_5A00);
      issue(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_005A, 1'b0, 2);
      beats.delete();

      // Word-crossing accesses, including address wrap.
      mem[30'h3F] = 32'h1122_3344;
      mem[30'h40] = 32'h5566_7788;
`ifdef MEM_MISALIGN_SPLIT_EN
      issue(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h7788_1122, 1'b0, 3);
      check("split_lw_beats", beats.size(), 2);
      check_beat("split_lw0", 32'h0FC, 1'b0, 4'h0, 32'h0);
      check_beat("split_lw1", 32'h100, 1'b0, 4'h0, 32'h0);
      issue(1'b1, 3'b010, 32'h0FF, 32'hAABB_CCDD, 32'h0, 1'b0, 3);
      check_beat("split_sw0", 32'h0FC, 1'b1, 4'b1000, 32'hDD00_0000);
      check_beat("split_sw1", 32'h100, 1'b1, 4'b0111, 32'h00AA_BBCC);
      issue(1'b0, 3'b010, 32'h0FE, 32'h0, 32'hBBCC_DD22, 1'b0, 3);
      beats.delete();
      mem[30'h3FFF_FFFF] = 32'hAB00_0000;
      mem[30'h0]         = 32'h0000_00CD;
      issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_CDAB, 1'b0, 3);
      check_beat("wrap_lh0", 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0);
      check_beat("wrap_lh1", 32'h0000_0000, 1'b0, 4'h0, 32'h0);
`else
      issue(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, 3'b010, 32'h0FF, 32'hAABB_CCDD, 32'h0, 1'b1, 1);
      issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1);
      check("nosplit_no_req", beats.size(), 0);
`endif
      beats.delete();

      // Illegal RWType codes never reach the bus.
      issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, 3'b100, 32'h100, 32'hFF, 32'h0, 1'b1, 1);
      issue(1'b1, 3'b101, 32'h100, 32'hFF, 32'h0, 1'b1, 1);
      check("illegal_no_req", beats.size(), 0);

      // Slow backend: three wait cycles per beat.
      ack_delay = 3;
      mem[30'h40] = 32'hCAFE_F00D;
      issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0, 5);
      issue(1'b1, 3'b010, 32'h104, 32'h0102_0304, 32'h0, 1'b0, 5);
      check("slow_beats", beats.size(), 2);
      beats.delete();

      // Reset while ACC0 waits for ack, then a stray ack.
      ack_delay = 1000;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.MemRW     = 1'b0;
      bus.RWType    = 3'b010;
      bus.addr      = 32'h100;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("abort_pre_req", bus.mem_req, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_mem_req", bus.mem_req, 1'b0);
      check("abort_ready", bus.req_ready, 1'b1);
      check("abort_resp", bus.resp_valid, 1'b0);
      stray_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("stray_mem_req", bus.mem_req, 1'b0);
         check("stray_resp", bus.resp_valid, 1'b0);
      end
      stray_ack = 1'b0;
      ack_delay = 0;
      repeat (2) @(negedge clk);
      check("abort_no_beat", beats.size(), 0);
      check("stray_ready", bus.req_ready, 1'b1);

      // Normal operation resumes.
      issue(1'b0, 3'b010, 32'h104, 32'h0, 32'h0102_0304, 1'b0, 2);
      check_beat("recover_lw", 32'h104, 1'b0, 4'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
